seven_segment_mux: RTL

- Parametrised time-multiplexed driver for a common-anode/cathode seven-segment bank of DIGITS digits.
- Scans one digit per refresh slot and shows hex digits 0-F.
- Features: per-digit decimal points, leading-zero blanking, PWM brightness, and input sampling aligned to the frame boundary (tear-free).
- Sits between board-level display pins and any logic that produces a packed 4*DIGITS-bit hex value.

---
 rtl/seven_segment_mux.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver: scans DIGITS hex digits one slot at a
// time, with per-digit decimal points, leading-zero blanking and PWM dimming.
// Inputs are latched only at the frame boundary, so a frame never shows a mix
// of old and new values.
module seven_segment_mux #(
    parameter int DIGITS         = 4,
    parameter int DIV_WIDTH      = 16,
    parameter int BRIGHT_WIDTH   = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_Reset_n,
    input  logic [4*DIGITS-1:0]     i_Data,
    input  logic [DIGITS-1:0]       i_Dp,
    input  logic                    i_Blank_Zero,
    input  logic [BRIGHT_WIDTH-1:0] i_Brightness,
    output logic [DIGITS-1:0]       o_Chosen_Segment,
    output logic [7:0]              o_SevenSegmentDisplay,
    output logic                    o_Frame_Start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    // XOR masks that turn internal active-high patterns into pin polarity;
    // they are also the "everything off" pin values.
    localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // Scan state
    logic [DIV_WIDTH-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    frame_start;

    // Shadow copies of the inputs, refreshed once per frame
    logic [4*DIGITS-1:0]     data_q, data_d;
    logic [DIGITS-1:0]       dp_q, dp_d;
    logic                    blank_q, blank_d;
    logic [BRIGHT_WIDTH-1:0] bright_q, bright_d;

    // Registered pin drivers
    logic [DIGITS-1:0]       an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    frame_q;

    // Per-digit views of the value being displayed this frame
    logic [3:0]              nib [DIGITS];
    logic [DIGITS-1:0]       nib_nz;
    logic [BRIGHT_WIDTH-1:0] phase;

    // Active-high abcdefg pattern (a on bit 0) for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // The _d shadow values are used below so that digit 0 of a new frame
    // already shows the value captured at that frame's start.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi]    = data_d[4*gi +: 4];
        assign nib_nz[gi] = |data_d[4*gi +: 4];
    end

    assign phase = presc_q[DIV_WIDTH-1 -: BRIGHT_WIDTH];

    // Prescaler/digit advance and frame-boundary capture of the inputs
    always_comb begin
        frame_start = (presc_q == '0) && (idx_q == '0);
        presc_d     = presc_q + DIV_WIDTH'(1);
        idx_d       = idx_q;
        if (&presc_q) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        data_d   = data_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        bright_d = bright_q;
        if (frame_start) begin
            data_d   = i_Data;
            dp_d     = i_Dp;
            blank_d  = i_Blank_Zero;
            bright_d = i_Brightness;
        end
    end

    // Decode the current digit, apply blanking and PWM, convert to pin polarity
    always_comb begin
        logic              upper_zero;
        logic [7:0]        seg_hi;
        logic [DIGITS-1:0] an_hot;
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if ((k >= int'(idx_q)) && nib_nz[k]) begin
                upper_zero = 1'b0;
            end
        end
        seg_hi = {dp_d[idx_q], hex_to_seg(nib[idx_q])};
        // A blanked digit keeps its decimal point
        if (blank_d && (idx_q != '0) && upper_zero) begin
            seg_hi[6:0] = '0;
        end
        an_hot = DIGITS'(1) << idx_q;
        if (phase > bright_d) begin
            an_hot = '0;
            seg_hi = '0;
        end
        an_d  = an_hot ^ AN_OFF;
        seg_d = seg_hi ^ SEG_OFF;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_Reset_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            dp_q     <= '0;
            blank_q  <= 1'b0;
            bright_q <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            frame_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            bright_q <= bright_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            frame_q  <= frame_start;
        end
    end

    assign o_Chosen_Segment      = an_q;
    assign o_SevenSegmentDisplay = seg_q;
    assign o_Frame_Start         = frame_q;

endmodule
